// File: rtl/l17_pkg.sv
// Shared constants and FSM state type for the layer-17 result write-back path.
package l17_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned N_LANES = 16;
  localparam int unsigned PIX_L17 = 196;
  localparam int unsigned GRP_L17 = 4;
  localparam int unsigned BEAT_W  = N_LANES * DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/sync_fifo_l17.sv
// Small synchronous FIFO buffering result beats ahead of the BRAM2 write port.
// Push is refused by the caller at full; there is no pass-through path.
module sync_fifo_l17 #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     not_empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_next;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (pop && !push) begin
      count_next = count - CW'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      not_empty <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count     <= count_next;
      not_empty <= (count_next != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/l17_result_writer.sv
// Layer-17 result writer: buffers un-stallable MAC-array beats and writes them
// linearly into BRAM2 through an arbitrated port; flags completion and loss.
module l17_result_writer #(
  parameter int unsigned N_LANES    = l17_pkg::N_LANES,
  parameter int unsigned DATA_W     = l17_pkg::DATA_W,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned PIX        = l17_pkg::PIX_L17,
  parameter int unsigned CH_GROUPS  = l17_pkg::GRP_L17,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic                        in_valid,
  input  logic [N_LANES*DATA_W-1:0]   in_data,
  output logic                        in_ready,
  input  logic                        wr_gnt,
  output logic                        wr_en,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [N_LANES*DATA_W-1:0]   wr_data,
  output logic                        busy,
  output logic                        done,
  output logic                        ovf
);

  import l17_pkg::*;

  localparam int unsigned BW    = N_LANES * DATA_W;
  localparam int unsigned TOTAL = PIX * CH_GROUPS;
  localparam int unsigned AW    = $clog2(TOTAL + 1);
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;

  state_e            state;
  state_e            state_next;
  logic [AW-1:0]     acc_cnt;
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] base;
  logic [CW-1:0]     count;
  logic              fifo_ne;
  logic [BW-1:0]     head;
  logic              push;
  logic              pop;
  logic              busy_next;
  logic              done_next;

  // Readiness depends only on state and counters, never on in_valid.
  assign in_ready = (state == RUN) && (count < CW'(FIFO_DEPTH)) && (acc_cnt < AW'(TOTAL));
  assign push     = in_valid && in_ready;
  assign pop      = fifo_ne && wr_gnt;

  assign wr_en   = fifo_ne;
  assign wr_addr = base + wr_idx;
  assign wr_data = fifo_ne ? head : '0;

  sync_fifo_l17 #(
    .WIDTH (BW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .din       (in_data),
    .dout      (head),
    .count     (count),
    .not_empty (fifo_ne)
  );

  always_comb begin
    state_next = state;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (push && (acc_cnt == AW'(TOTAL - 1))) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (count == CW'(1))) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      acc_cnt <= '0;
      wr_idx  <= '0;
      base    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= busy_next;
      done  <= done_next;
      if (in_valid && !in_ready) begin
        ovf <= 1'b1;
      end
      // A new frame restarts the counters; the FIFO is empty in IDLE.
      if ((state == IDLE) && start) begin
        acc_cnt <= '0;
        wr_idx  <= '0;
        base    <= base_addr;
      end else begin
        if (push) begin
          acc_cnt <= acc_cnt + AW'(1);
        end
        if (pop) begin
          wr_idx <= wr_idx + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/l17_result_writer.md
# l17_result_writer

Write-back side of the layer-17 MAC array. Accepts the 16-lane result vector the adder-tree array produces per output pixel, buffers it in a small FIFO, and writes it into the output BRAM (BRAM2) in linear pixel-major, channel-group order. The BRAM2 write port is shared with the next layer's reader, so writes are granted by an arbiter. The block reports frame completion and flags data loss, because the array cannot be stalled.

## Interface
- N_LANES, 16, result lanes per beat
- DATA_W, 16, bits per lane
- ADDR_W, 12, BRAM2 word-address width
- PIX, 196, output pixels per channel group (14x14)
- CH_GROUPS, 4, channel groups per frame (64 ch / 16 lanes)
- FIFO_DEPTH, 4, result buffer depth (power of two)
---
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; arms a frame; ignored unless IDLE
- base_addr  in  ADDR_W  BRAM2 frame base; sampled on accepted start
- in_valid  in  1  result beat present (array output, no backpressure)
- in_data  in  N_LANES*DATA_W  result beat; lane i at bits [(i+1)*16-1:i*16]
- in_ready  out  1  beat will be accepted this cycle
- wr_gnt  in  1  arbiter grants BRAM2 write port this cycle
- wr_en  out  1  write request
- wr_addr  out  ADDR_W  write address
- wr_data  out  N_LANES*DATA_W  write data
- busy  out  1  frame in progress
- done  out  1  one-cycle frame-complete pulse
- ovf  out  1  sticky: a beat was dropped

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN on start. Clear `acc_cnt` and `wr_idx`, latch base_addr, leave ovf unchanged.
- Push when state==RUN && in_valid && count<FIFO_DEPTH && acc_cnt<PIX*CH_GROUPS.
- in_ready = state==RUN && count<FIFO_DEPTH && acc_cnt<PIX*CH_GROUPS.
- Pass-through at full is not supported.
- RUN -> DRAIN in the cycle the beat with acc_cnt==PIX*CH_GROUPS-1 is pushed.
- DRAIN -> IDLE when the final pop occurs (count 1 -> 0). done=1 in the following cycle.
- wr_en = count!=0. wr_data = FIFO head. wr_addr = base + wr_idx, modulo 2^ADDR_W (wraps silently).
- Pop on wr_en && wr_gnt. wr_idx increments on pop.
- Simultaneous push and pop: count unchanged, both take effect.
- ovf set when in_valid && !in_ready, in any state. Examples: beat in IDLE, beat after the frame is full, beat while the FIFO is full. The dropped beat is never written.
- ovf clears only on reset.
- start while RUN or DRAIN: ignored, no effect.
- wr_gnt without wr_en: no effect.

## Timing
- Reset values: state IDLE, count 0, in_ready 0, wr_en 0, wr_addr 0, wr_data 0, busy 0, done 0, ovf 0.
- Reset mid-frame discards FIFO contents; no further writes are issued.
- Beat pushed in cycle t: earliest wr_en for it is t+1. With wr_gnt held high, the pipeline latency is 1 and sustains one write per cycle.
- busy = state!=IDLE, registered. It rises the cycle after start and falls in the same cycle done rises.
- done is high for exactly one cycle, the cycle after the final write handshake.
- Every output except wr_data/wr_addr is a direct register. wr_data and wr_addr are driven from registered storage only, with no input-to-output combinational path, except in_ready, which depends only on state and counters.

## Structure
- Package l17_pkg holds:
  - DATA_W, N_LANES
  - PIX_L17=196, GRP_L17=4
  - the state enum {IDLE, RUN, DRAIN}
  - the beat-vector width localparam
- Sub-module sync_fifo_l17 (width N_LANES*DATA_W, depth FIFO_DEPTH, count output, no pass-through).
- Top-level l17_result_writer holds the FSM, counters, address adder and ovf.

## Test plan
Bench config: PIX=4, CH_GROUPS=2, base 0x100.
- Basic frame: start, 8 consecutive beats with data=k, wr_gnt=1 -> writes 0x100..0x107 with data 0..7; done one cycle after the last write; busy low in that cycle; ovf=0.
- Grant stalls: wr_gnt low for 3 cycles after the 2nd beat while beats continue -> FIFO reaches count 4; the 7th concurrent beat is dropped with ovf=1; addresses stay contiguous for accepted beats.
- Beats outside a frame: in_valid in IDLE -> no wr_en, ovf=1. A 9th beat after the 8th -> dropped, ovf=1.
- Wrap-around: base 0xFFE, 8 beats -> addresses 0xFFE, 0xFFF, 0x000..0x005.
- Reset mid-frame: rst=0 after 3 beats with 2 beats still buffered -> next cycle wr_en=0, busy=0, ovf=0. A fresh start then completes a normal 8-beat frame.
- Start while busy: second start during RUN -> ignored; base unchanged; a single done.
